// File: rtl/data_mem_pipe.sv
// Pipelined word-addressed data memory for the LC2K core: valid/ready request channel,
// fixed-latency response channel with backpressure, range checking and a debug read port.
module data_mem_pipe #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH   = 65536,
  parameter int unsigned LATENCY = 1,
  parameter int unsigned ADDR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_we,
  output logic              rsp_err,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [15:0]       err_cnt
);

  localparam logic [DATA_W:0] DepthReq = (DATA_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] DepthDbg = (ADDR_W + 1)'(DEPTH);

  // Zero at time 0; reset deliberately leaves the contents alone.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  logic              advance;
  logic              accept;
  logic              in_range;
  logic              dbg_in_range;
  logic [ADDR_W-1:0] req_idx;

  logic              s0_we;
  logic              s0_err;
  logic [DATA_W-1:0] s0_data;

  // Stage 0 captures the array access on the accept edge; stages 1..LATENCY delay it so
  // rsp_valid rises LATENCY edges after the accept.
  logic [LATENCY:0]  vld_q;
  logic [LATENCY:0]  we_q;
  logic [LATENCY:0]  err_q;
  logic [DATA_W-1:0] data_q [LATENCY+1];

  logic [15:0]       err_cnt_q;
  logic [DATA_W-1:0] dbg_rdata_q;

  assign rsp_valid    = vld_q[LATENCY];
  assign rsp_we       = we_q[LATENCY];
  assign rsp_err      = err_q[LATENCY];
  assign rsp_rdata    = data_q[LATENCY];
  assign err_cnt      = err_cnt_q;
  assign dbg_rdata    = dbg_rdata_q;

  assign advance      = !rsp_valid || rsp_ready;
  assign req_ready    = rst_n && advance;
  assign accept       = req_valid && req_ready;
  assign in_range     = {1'b0, req_addr} < DepthReq;
  assign dbg_in_range = {1'b0, dbg_addr} < DepthDbg;
  assign req_idx      = req_addr[ADDR_W-1:0];

  always_comb begin
    s0_we   = accept && req_we;
    s0_err  = accept && !in_range;
    s0_data = '0;
    if (accept && !req_we && in_range) begin
      s0_data = mem[req_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (accept && req_we && in_range) begin
      mem[req_idx] <= req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      we_q  <= '0;
      err_q <= '0;
      for (int i = 0; i <= int'(LATENCY); i++) begin
        data_q[i] <= '0;
      end
    end else if (advance) begin
      vld_q[0]  <= accept;
      we_q[0]   <= s0_we;
      err_q[0]  <= s0_err;
      data_q[0] <= s0_data;
      for (int i = 1; i <= int'(LATENCY); i++) begin
        vld_q[i]  <= vld_q[i-1];
        we_q[i]   <= we_q[i-1];
        err_q[i]  <= err_q[i-1];
        data_q[i] <= data_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (accept && !in_range && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  // Reads the pre-write contents, so a same-edge write shows up one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbg_rdata_q <= '0;
    end else begin
      dbg_rdata_q <= dbg_in_range ? mem[dbg_addr] : '0;
    end
  end

endmodule
